ex_muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide engine with its own sequencing FSM, sitting beside the EX-stage ALU.
- EX raises start_i for M-extension ops (funct7 = 0000001).
- The unit freezes the pipeline through stall_o while it computes, then presents result_o for one cycle with done_o.
- The hazard unit ORs stall_o into the global pipeline stall.

---
 rtl/ex_muldiv_unit_if.sv | 29 ++
 rtl/ex_muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit_if
// Purpose  : EX-stage handshake between the pipeline and the mul/div engine.
// Revision : 1.0
// ============================================================================
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output stall_o, done_o, result_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : Iterative RV32M multiply/divide engine, one bit per cycle.
// Revision : 1.0
// ============================================================================
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  ex_muldiv_unit_if.slave  bus
);
  localparam int c_CNT_W = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opd;
  logic [2:0]         r_op;
  logic               r_neg_result;
  logic               r_neg_rem;
  logic [WIDTH-1:0]   r_result;

  logic               w_is_div;
  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_accept;
  logic               w_div_zero;
  logic               w_overflow;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_final;

  // MULH, MULHSU (a only), DIV and REM treat operands as signed.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (bus.op_i)
      3'd1, 3'd4, 3'd6: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      3'd2:    w_a_signed = 1'b1;
      default: ;
    endcase
  end

  assign w_is_div   = bus.op_i[2];
  assign w_a_neg    = w_a_signed & bus.a_i[WIDTH-1];
  assign w_b_neg    = w_b_signed & bus.b_i[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -bus.a_i : bus.a_i;
  assign w_b_mag    = w_b_neg ? -bus.b_i : bus.b_i;
  assign w_accept   = (r_state == c_IDLE) & bus.start_i & ~bus.flush_i;
  assign w_div_zero = w_is_div & (bus.b_i == '0);
  assign w_overflow = w_is_div & ~bus.op_i[0] & (bus.a_i == c_MIN) & (bus.b_i == '1);

  // Multiply: r_acc = {partial product, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opd};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide: r_acc = {partial remainder, dividend bits / quotient bits}.
  assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opd};
  assign w_div_next  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                          : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;
  assign w_prod     = r_neg_result ? -w_acc_next : w_acc_next;
  assign w_quot     = r_neg_result ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0];
  assign w_rem      = r_neg_rem ? -w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[2*WIDTH-1:WIDTH];

  always_comb begin
    w_final = w_prod[WIDTH-1:0];
    case (r_op)
      3'd0:             w_final = w_prod[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: w_final = w_prod[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       w_final = w_quot;
      default:          w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_opd        <= '0;
      r_op         <= '0;
      r_neg_result <= 1'b0;
      r_neg_rem    <= 1'b0;
      r_result     <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_op  <= bus.op_i;
            r_cnt <= '0;
            if (w_div_zero) begin
              r_result <= bus.op_i[1] ? bus.a_i : '1;
              r_state  <= c_DONE;
            end else if (w_overflow) begin
              r_result <= bus.op_i[1] ? '0 : c_MIN;
              r_state  <= c_DONE;
            end else begin
              r_acc        <= {{WIDTH{1'b0}}, w_a_mag};
              r_opd        <= w_b_mag;
              r_neg_result <= w_a_neg ^ w_b_neg;
              r_neg_rem    <= w_a_neg;
              r_state      <= c_CALC;
            end
          end
        end
        c_CALC: begin
          if (bus.flush_i) begin
            r_state <= c_IDLE;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + c_CNT_W'(1);
            // Final step's result is sign-corrected and registered directly.
            if (r_cnt == c_LAST) begin
              r_result <= w_final;
              r_state  <= c_DONE;
            end
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.stall_o  = ((r_state == c_IDLE) & bus.start_i & ~bus.flush_i) |
                        ((r_state == c_CALC) & ~bus.flush_i);
  assign bus.done_o   = (r_state == c_DONE) & ~bus.flush_i;
  assign bus.result_o = r_result;
endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Purpose  : Directed self-checking bench for the RV32M mul/div engine.
// Revision : 1.0
// ============================================================================
module tb_ex_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.WIDTH(32)) bus ();
  ex_muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // RV32M reference using 64-bit language arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> 32;
      3'd2: r = (sa * ub) >>> 32;
      3'd3: r = (ua * ub) >> 32;
      3'd4: r = (b == 0) ? -64'sd1 : sa / sb;
      3'd5: r = (b == 0) ? -64'sd1 : ua / ub;
      3'd6: r = (b == 0) ? sa : sa % sb;
      default: r = (b == 0) ? ua : ua % ub;
    endcase
    return r[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Every done_o must retire the oldest outstanding expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done_o=1, expected 0");
      end else begin
        check("model_result", bus.result_o, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
    int stalls, cyc, done_cyc;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    exp_q.push_back(model(op, a, b));
    stalls = 0;
    cyc = 0;
    done_cyc = 0;
    while (done_cyc == 0 && cyc < 100) begin
      cyc++;
      @(negedge clk);
      if (bus.stall_o === 1'b1) stalls++;
      if (bus.done_o === 1'b1) begin
        done_cyc = cyc;
        check({name, "_result"}, bus.result_o, exp);
      end
      @(posedge clk);
      #1;
    end
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    check({name, "_done_cycle"}, 32'(done_cyc), 32'(exp_stall + 1));
  endtask

  task automatic idle_cycle();
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = 3'd0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_stall", {31'd0, bus.stall_o}, 32'd0);
    check("reset_done", {31'd0, bus.done_o}, 32'd0);
    check("reset_result", bus.result_o, 32'd0);
    @(posedge clk);
    #1;

    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    idle_cycle();

    run_op("mulh_min_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhu_max_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu_m1_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    idle_cycle();

    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    idle_cycle();

    run_op("divu_by_zero", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_by_zero", 3'd6, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    idle_cycle();

    // Flush at CALC cycle 10 (cycle 11 counted from the accept cycle).
    bus.start_i = 1'b1;
    bus.op_i    = 3'd0;
    bus.a_i     = 32'h0000_1234;
    bus.b_i     = 32'd5;
    repeat (10) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(negedge clk);
    check("calc_flush_stall", {31'd0, bus.stall_o}, 32'd0);
    check("calc_flush_done", {31'd0, bus.done_o}, 32'd0);
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("after_flush_stall", {31'd0, bus.stall_o}, 32'd0);
    check("after_flush_done", {31'd0, bus.done_o}, 32'd0);
    @(posedge clk);
    #1;
    run_op("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, 33);
    idle_cycle();

    // Reset at CALC cycle 20 abandons the operation and clears result_o.
    bus.start_i = 1'b1;
    bus.op_i    = 3'd5;
    bus.a_i     = 32'd100;
    bus.b_i     = 32'd7;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("midcalc_rst_stall", {31'd0, bus.stall_o}, 32'd0);
    check("midcalc_rst_done", {31'd0, bus.done_o}, 32'd0);
    check("midcalc_rst_result", bus.result_o, 32'd0);
    @(posedge clk);
    #1;

    // flush_i together with start_i in IDLE: no accept.
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.op_i    = 3'd5;
    bus.a_i     = 32'd5;
    bus.b_i     = 32'd0;
    @(negedge clk);
    check("idle_flush_stall", {31'd0, bus.stall_o}, 32'd0);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("idle_flush_next_stall", {31'd0, bus.stall_o}, 32'd0);
    check("idle_flush_next_done", {31'd0, bus.done_o}, 32'd0);
    @(posedge clk);
    #1;

    // flush_i in the DONE cycle suppresses done_o.
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(negedge clk);
    check("done_flush_done", {31'd0, bus.done_o}, 32'd0);
    check("done_flush_stall", {31'd0, bus.stall_o}, 32'd0);
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_pending_results", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
